// File: rtl/ysyx_22050550_pc_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM encodings, instruction width
// and the reset PC used by both the sequencer and the PC register instance.
package ysyx_22050550_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_e;

    localparam int INST_W = 32;

    localparam logic [63:0] RESET_PC_VAL = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050550_pc_ctrl_pc_sel.sv
// Redirect priority mux: a trap beats mret, which beats a taken branch.
// The winning target is passed through untouched.
module ysyx_22050550_pc_sel
    import ysyx_22050550_pc_ctrl_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_target,
    input  logic            mret_valid,
    input  logic [PC_W-1:0] mret_target,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    output logic            redirect,
    output logic [PC_W-1:0] target
);

    always_comb begin
        redirect = trap_valid | mret_valid | br_valid;
        target   = '0;
        if (trap_valid) begin
            target = trap_target;
        end else if (mret_valid) begin
            target = mret_target;
        end else if (br_valid) begin
            target = br_target;
        end
    end

endmodule

// File: rtl/ysyx_22050550_pc_ctrl.sv
// Fetch sequencer: drives the PC register write port, runs the single-outstanding
// fetch handshake and buffers the fetched instruction for the decode stage.
module ysyx_22050550_pc_ctrl
    import ysyx_22050550_pc_ctrl_pkg::*;
#(
    parameter int            PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   cur_pc,
    output logic              pc_we,
    output logic [PC_W-1:0]   pc_next,
    input  logic              trap_valid,
    input  logic [PC_W-1:0]   trap_target,
    input  logic              mret_valid,
    input  logic [PC_W-1:0]   mret_target,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_target,
    output logic              if_req_valid,
    output logic [PC_W-1:0]   if_req_addr,
    input  logic              if_req_ready,
    input  logic              if_rsp_valid,
    input  logic [INST_W-1:0] if_rsp_inst,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              id_ready
);

    fetch_state_e      state, state_nx;
    logic              kill, kill_nx;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   inst_pc_q;
    logic              redirect;
    logic [PC_W-1:0]   redir_target;
    logic              handoff;
    logic              req_fire;
    logic              rsp_take;

    ysyx_22050550_pc_sel #(
        .PC_W (PC_W)
    ) u_pc_sel (
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .mret_valid  (mret_valid),
        .mret_target (mret_target),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .redirect    (redirect),
        .target      (redir_target)
    );

    always_comb begin
        state_nx     = state;
        kill_nx      = kill;
        if_req_valid = 1'b0;
        inst_valid   = 1'b0;
        pc_we        = 1'b0;
        pc_next      = '0;
        handoff      = 1'b0;
        req_fire     = 1'b0;
        rsp_take     = 1'b0;
        case (state)
            FETCH_REQ: begin
                if_req_valid = ~redirect & ~rst;
                req_fire     = if_req_valid & if_req_ready;
                if (req_fire) begin
                    state_nx = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // A response that belongs to a redirected-away path is dropped.
                if (if_rsp_valid) begin
                    kill_nx = 1'b0;
                    if (kill | redirect) begin
                        state_nx = FETCH_REQ;
                    end else begin
                        rsp_take = 1'b1;
                        state_nx = FETCH_HOLD;
                    end
                end else if (redirect) begin
                    kill_nx = 1'b1;
                end
            end
            FETCH_HOLD: begin
                inst_valid = ~redirect & ~rst;
                handoff    = inst_valid & id_ready;
                if (redirect | handoff) begin
                    state_nx = FETCH_REQ;
                end
            end
            default: begin
                state_nx = FETCH_REQ;
            end
        endcase

        if (redirect & ~rst) begin
            pc_we   = 1'b1;
            pc_next = redir_target;
        end else if (handoff) begin
            pc_we   = 1'b1;
            pc_next = cur_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_REQ;
            kill      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            if (req_fire) begin
                inst_pc_q <= cur_pc;
            end
            if (rsp_take) begin
                inst_q <= if_rsp_inst;
            end
        end
    end

    assign if_req_addr = cur_pc;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;

endmodule
